// File: rtl/matrix_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_read_arbiter
//  Description : Round-robin arbiter sharing the single matrix_storage read
//                port among NUM_REQ requesters. Validates each request, issues
//                one read strobe, waits for rd_ready (or times out), captures
//                the matrix and pulses a per-requester valid/error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_read_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int MAX_DIM        = 5,
    parameter int MAX_MATRIX_ID  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_col,
    input  logic [3*NUM_REQ-1:0]   req_row,
    input  logic [2*NUM_REQ-1:0]   req_mat_index,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [NUM_REQ-1:0]     resp_error,
    output logic [199:0]           resp_data,
    output logic                   busy,
    output logic                   read_en,
    output logic [2:0]             rd_col,
    output logic [2:0]             rd_row,
    output logic [1:0]             rd_mat_index,
    input  logic [199:0]           rd_data_flow,
    input  logic                   rd_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // INVALID holds the grant for one cycle so an illegal request's error
    // strobe lands two cycles after the request is sampled.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_INVALID = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [IDX_W-1:0] r_win;
    logic [IDX_W-1:0] r_rr_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ok;

    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic             w_legal;
    logic [2:0]       w_col_a [NUM_REQ];
    logic [2:0]       w_row_a [NUM_REQ];
    logic [1:0]       w_idx_a [NUM_REQ];

    // Unpack the flat per-requester address buses
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_col_a[g] = req_col[3*g +: 3];
        assign w_row_a[g] = req_row[3*g +: 3];
        assign w_idx_a[g] = req_mat_index[2*g +: 2];
    end

    // Round-robin winner: first set request scanning upward from rr_last+1
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = int'(r_rr_last) + k;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            if (!w_found && req[v_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[IDX_W-1:0];
            end
        end
    end

    // Legality of the winner's address fields
    always_comb begin
        w_legal = (int'(w_col_a[w_win]) >= 1) && (int'(w_col_a[w_win]) <= MAX_DIM) &&
                  (int'(w_row_a[w_win]) >= 1) && (int'(w_row_a[w_win]) <= MAX_DIM) &&
                  (int'(w_idx_a[w_win]) < MAX_MATRIX_ID);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; rd_ready on the timeout cycle still counts as success
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next = w_legal ? S_WAIT : S_INVALID;
            S_WAIT:    if (rd_ready || (r_cnt == C_CNT_LAST)) w_next = S_RESP;
            S_INVALID: w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Transaction datapath: winner, read fields, wait counter, captured data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win        <= '0;
            r_rr_last    <= IDX_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_ok         <= 1'b0;
            resp_data    <= '0;
            rd_col       <= '0;
            rd_row       <= '0;
            rd_mat_index <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win <= w_win;
                        r_ok  <= 1'b0;
                        r_cnt <= '0;
                        if (w_legal) begin
                            rd_col       <= w_col_a[w_win];
                            rd_row       <= w_row_a[w_win];
                            rd_mat_index <= w_idx_a[w_win];
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (rd_ready) begin
                        resp_data <= rd_data_flow;
                        r_ok      <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_rr_last <= r_win;
                    r_cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; read_en marks the first WAIT cycle
    always_comb begin
        gnt        = '0;
        resp_valid = '0;
        resp_error = '0;
        busy       = (r_state != S_IDLE);
        read_en    = (r_state == S_WAIT) && (r_cnt == '0);
        if (r_state != S_IDLE) gnt[r_win] = 1'b1;
        if (r_state == S_RESP) begin
            if (r_ok) resp_valid[r_win] = 1'b1;
            else      resp_error[r_win] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_read_arbiter
//  Description : Self-checking bench for matrix_read_arbiter. Transactions
//                are checked against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_read_arbiter;

    localparam int N  = 3;
    localparam int TO = 255;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [3*N-1:0] req_col;
    logic [3*N-1:0] req_row;
    logic [2*N-1:0] req_mat_index;
    logic [N-1:0]   gnt;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_error;
    logic [199:0]   resp_data;
    logic           busy;
    logic           read_en;
    logic [2:0]     rd_col;
    logic [2:0]     rd_row;
    logic [1:0]     rd_mat_index;
    logic [199:0]   rd_data_flow;
    logic           rd_ready;

    matrix_read_arbiter #(
        .NUM_REQ(N), .MAX_DIM(5), .MAX_MATRIX_ID(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_col(req_col), .req_row(req_row),
        .req_mat_index(req_mat_index), .gnt(gnt), .resp_valid(resp_valid),
        .resp_error(resp_error), .resp_data(resp_data), .busy(busy), .read_en(read_en),
        .rd_col(rd_col), .rd_row(rd_row), .rd_mat_index(rd_mat_index),
        .rd_data_flow(rd_data_flow), .rd_ready(rd_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int           m_rr;
    logic [2:0]   m_col;
    logic [2:0]   m_row;
    logic [1:0]   m_idx;
    logic [199:0] m_data;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] rand200();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[199:0];
    endfunction

    // Round-robin choice: first requester after the last served one, wrapping
    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // Randomise every requester's address fields; bias = percent forced legal
    task automatic rand_fields(input int bias);
        for (int i = 0; i < N; i++) begin
            if (int'($urandom_range(99)) < bias) begin
                req_col[3*i +: 3]       = 3'($urandom_range(1, 5));
                req_row[3*i +: 3]       = 3'($urandom_range(1, 5));
                req_mat_index[2*i +: 2] = 2'($urandom_range(0, 1));
            end else begin
                req_col[3*i +: 3]       = 3'($urandom_range(0, 7));
                req_row[3*i +: 3]       = 3'($urandom_range(0, 7));
                req_mat_index[2*i +: 2] = 2'($urandom_range(0, 3));
            end
        end
    endtask

    // One full transaction starting from an IDLE cycle; delay = WAIT cycles
    // before rd_ready (>= TO means it never comes); keep = hold req afterwards
    task automatic run_txn(input logic [N-1:0] r, input int delay, input bit keep);
        int           w;
        bit           legal;
        bit           hit;
        logic [2:0]   c;
        logic [2:0]   ro;
        logic [1:0]   mi;
        logic [199:0] d;
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt, 0);
        check("idle_data", resp_data, m_data);
        req = r;
        step();
        w  = pick(r);
        c  = req_col[3*w +: 3];
        ro = req_row[3*w +: 3];
        mi = req_mat_index[2*w +: 2];
        legal = (c >= 1) && (c <= 5) && (ro >= 1) && (ro <= 5) && (mi < 2);
        if (legal) begin
            m_col = c;
            m_row = ro;
            m_idx = mi;
        end
        hit = 1'b0;
        check("grant_gnt", gnt, N'(1) << w);
        check("grant_busy", busy, 1);
        check("grant_read_en", read_en, legal);
        check("grant_rd_fields", {rd_col, rd_row, rd_mat_index}, {m_col, m_row, m_idx});
        check("grant_strobes", {resp_valid, resp_error}, 0);
        // Address changes after the grant must have no effect
        rand_fields(0);
        if (legal) begin
            for (int k = 0; k < TO; k++) begin
                if (k > 0) begin
                    check("wait_gnt", gnt, N'(1) << w);
                    check("wait_read_en", read_en, 0);
                    check("wait_strobes", {resp_valid, resp_error}, 0);
                end
                if (!keep && ($urandom_range(3) == 0)) req[w] = 1'b0;
                if (k == delay) begin
                    d            = rand200();
                    rd_data_flow = d;
                    rd_ready     = 1'b1;
                    step();
                    rd_ready     = 1'b0;
                    rd_data_flow = rand200();
                    hit          = 1'b1;
                    break;
                end
                step();
            end
            if (hit) m_data = d;
        end else begin
            step();
        end
        // Response cycle
        check("resp_gnt", gnt, N'(1) << w);
        check("resp_valid", resp_valid, hit ? (N'(1) << w) : N'(0));
        check("resp_error", resp_error, hit ? N'(0) : (N'(1) << w));
        check("resp_data", resp_data, m_data);
        check("resp_rd_fields", {rd_col, rd_row, rd_mat_index}, {m_col, m_row, m_idx});
        m_rr = w;
        if (!keep) req = '0;
        // A stray rd_ready here must be ignored
        if ($urandom_range(1) == 0) begin
            rd_data_flow = rand200();
            rd_ready     = 1'b1;
        end
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        int delay;
        logic [N-1:0] r;
        rst_n         = 1'b0;
        req           = '0;
        req_col       = '0;
        req_row       = '0;
        req_mat_index = '0;
        rd_data_flow  = '0;
        rd_ready      = 1'b0;
        m_rr  = N - 1;
        m_col = '0;
        m_row = '0;
        m_idx = '0;
        m_data = '0;
        step();
        step();
        check("reset_outputs", {gnt, resp_valid, resp_error, busy, read_en}, 0);
        check("reset_rd_fields", {rd_col, rd_row, rd_mat_index}, 0);
        check("reset_data", resp_data, 0);
        rst_n = 1'b1;
        step();

        // Single legal request from requester 0, rd_ready two cycles after read_en
        rand_fields(100);
        req_col[2:0] = 3'd2;
        req_row[2:0] = 3'd3;
        req_mat_index[1:0] = 2'd1;
        run_txn(3'b001, 2, 1'b0);

        // All requesters held high: service order 0,1,2,0
        rand_fields(100);
        for (int i = 0; i < 4; i++) run_txn(3'b111, 1, 1'b1);
        req = '0;
        step();

        // Illegal requests on requester 1: col=6, idx=2, row=0
        rand_fields(100);
        req_col[5:3] = 3'd6;
        run_txn(3'b010, 0, 1'b0);
        rand_fields(100);
        req_mat_index[3:2] = 2'd2;
        run_txn(3'b010, 0, 1'b0);
        rand_fields(100);
        req_row[5:3] = 3'd0;
        run_txn(3'b010, 0, 1'b0);

        // Timeout, then rd_ready exactly on the timeout cycle
        rand_fields(100);
        run_txn(3'b100, TO, 1'b0);
        rand_fields(100);
        run_txn(3'b001, TO - 1, 1'b0);

        // Reset in WAIT, rd_ready after release must be ignored
        rand_fields(100);
        req = 3'b010;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {gnt, resp_valid, resp_error, busy, read_en}, 0);
        check("abort_rd_fields", {rd_col, rd_row, rd_mat_index}, 0);
        check("abort_data", resp_data, 0);
        m_rr  = N - 1;
        m_col = '0;
        m_row = '0;
        m_idx = '0;
        m_data = '0;
        step();
        rst_n = 1'b1;
        req   = '0;
        rd_data_flow = rand200();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_quiet", {gnt, resp_valid, resp_error, busy}, 0);
            step();
        end
        rand_fields(100);
        run_txn(3'b111, 0, 1'b0);

        // Randomised traffic
        for (int t = 0; t < 80; t++) begin
            rand_fields(70);
            r = N'($urandom_range(1, (1 << N) - 1));
            case ($urandom_range(19))
                0:       delay = TO;
                1:       delay = TO - 1;
                default: delay = int'($urandom_range(0, 6));
            endcase
            run_txn(r, delay, ($urandom_range(1) == 1));
            if ($urandom_range(3) == 0) begin
                req = '0;
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
